// File: rtl/tag_alloc_ctrl.sv
// Physical-tag free-list sequencer for rename: alloc grant, free merge queue.
// Ports: alloc_* (rename), free*_* (commit), fl_* (free-list FIFO), flush, stall_cycles, err.
module tag_alloc_ctrl #(
  parameter int TAG_W        = 8,
  parameter int FREE_Q_DEPTH = 4,
  parameter int RESERVE      = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             alloc_valid,
  input  logic [1:0]       alloc_cnt,
  output logic             alloc_ready,
  output logic [TAG_W-1:0] alloc_tag0,
  output logic [TAG_W-1:0] alloc_tag1,
  output logic [1:0]       alloc_tag_vld,
  input  logic             free0_valid,
  input  logic [TAG_W-1:0] free0_tag,
  input  logic             free1_valid,
  input  logic [TAG_W-1:0] free1_tag,
  output logic             free_ready,
  input  logic             flush,
  output logic             fl_reset,
  output logic             fl_read_1,
  output logic             fl_read_2,
  output logic             fl_write,
  output logic [TAG_W-1:0] fl_write_tag,
  input  logic [TAG_W-1:0] fl_tag0,
  input  logic [TAG_W-1:0] fl_tag1,
  input  logic [7:0]       fl_freespace,
  output logic [15:0]      stall_cycles,
  output logic             err
);

  localparam int AW = $clog2(FREE_Q_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    S_INIT,
    S_SETTLE,
    S_RUN,
    S_FLUSH
  } state_t;

  state_t state;

  logic [TAG_W-1:0] mem [FREE_Q_DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [CW-1:0]    count;

  logic       cnt_ok;
  logic [9:0] need;
  logic       space_ok;
  logic       grant;
  logic       q_active;
  logic       enq0;
  logic       enq1;
  logic       deq;
  logic       drop;
  logic [CW-1:0] count_nxt;

  assign cnt_ok   = (alloc_cnt == 2'd1) || (alloc_cnt == 2'd2);
  assign need     = 10'(alloc_cnt) + 10'(RESERVE);
  assign space_ok = {2'b00, fl_freespace} >= need;

  assign alloc_ready = (state == S_RUN) & ~flush & cnt_ok & space_ok;
  assign grant       = alloc_valid & alloc_ready;
  assign fl_read_1   = grant & (alloc_cnt == 2'd1);
  assign fl_read_2   = grant & (alloc_cnt == 2'd2);

  assign q_active   = (state == S_RUN) || (state == S_FLUSH);
  // Room for a full pair is required so both ports can always be taken together.
  assign free_ready = q_active & (count <= CW'(FREE_Q_DEPTH - 2));

  assign enq0 = free_ready & free0_valid;
  assign enq1 = free_ready & free1_valid;
  assign drop = ~free_ready & (free0_valid | free1_valid);

  // Head is only visible after it has been stored, so a freed tag never
  // bypasses the queue into the free list in its arrival cycle.
  assign deq          = q_active & (count != '0);
  assign fl_write     = deq;
  assign fl_write_tag = deq ? mem[rd_ptr] : '0;

  assign count_nxt = count + CW'(enq0) + CW'(enq1) - CW'(deq);

  always_ff @(posedge clk) begin
    if (enq0) mem[wr_ptr] <= free0_tag;
    if (enq1) mem[enq0 ? wr_ptr + AW'(1) : wr_ptr] <= free1_tag;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(enq0) + AW'(enq1);
      rd_ptr <= rd_ptr + AW'(deq);
      count  <= count_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_INIT;
      fl_reset <= 1'b1;
    end else begin
      unique case (state)
        S_INIT: begin
          state    <= S_SETTLE;
          fl_reset <= 1'b0;
        end
        S_SETTLE: state <= S_RUN;
        S_RUN: if (flush) state <= S_FLUSH;
        S_FLUSH: if (!flush && count == '0) state <= S_RUN;
        default: state <= S_INIT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      alloc_tag0    <= '0;
      alloc_tag1    <= '0;
      alloc_tag_vld <= 2'b00;
    end else begin
      alloc_tag_vld <= 2'b00;
      if (grant) begin
        alloc_tag0    <= fl_tag0;
        alloc_tag_vld <= fl_read_2 ? 2'b11 : 2'b01;
        if (fl_read_2) alloc_tag1 <= fl_tag1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cycles <= '0;
      err          <= 1'b0;
    end else begin
      if (state == S_RUN && alloc_valid && !alloc_ready &&
          stall_cycles != 16'hFFFF)
        stall_cycles <= stall_cycles + 16'd1;
      if ((alloc_valid && !cnt_ok) || drop)
        err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_tag_alloc_ctrl.sv
// Scoreboard bench for tag_alloc_ctrl: directed spec scenarios plus random traffic.
// A queue-based reference model predicts grants, frees and sticky status.
module tb_tag_alloc_ctrl;

  localparam int D   = 4;
  localparam int RES = 0;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       alloc_valid;
  logic [1:0] alloc_cnt;
  logic       alloc_ready;
  logic [7:0] alloc_tag0;
  logic [7:0] alloc_tag1;
  logic [1:0] alloc_tag_vld;
  logic       free0_valid;
  logic [7:0] free0_tag;
  logic       free1_valid;
  logic [7:0] free1_tag;
  logic       free_ready;
  logic       flush;
  logic       fl_reset;
  logic       fl_read_1;
  logic       fl_read_2;
  logic       fl_write;
  logic [7:0] fl_write_tag;
  logic [7:0] fl_tag0;
  logic [7:0] fl_tag1;
  logic [7:0] fl_freespace;
  logic [15:0] stall_cycles;
  logic       err;

  tag_alloc_ctrl #(.TAG_W(8), .FREE_Q_DEPTH(D), .RESERVE(RES)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .alloc_valid(alloc_valid),
    .alloc_cnt(alloc_cnt),
    .alloc_ready(alloc_ready),
    .alloc_tag0(alloc_tag0),
    .alloc_tag1(alloc_tag1),
    .alloc_tag_vld(alloc_tag_vld),
    .free0_valid(free0_valid),
    .free0_tag(free0_tag),
    .free1_valid(free1_valid),
    .free1_tag(free1_tag),
    .free_ready(free_ready),
    .flush(flush),
    .fl_reset(fl_reset),
    .fl_read_1(fl_read_1),
    .fl_read_2(fl_read_2),
    .fl_write(fl_write),
    .fl_write_tag(fl_write_tag),
    .fl_tag0(fl_tag0),
    .fl_tag1(fl_tag1),
    .fl_freespace(fl_freespace),
    .stall_cycles(stall_cycles),
    .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         due;
    logic [1:0] vld;
    logic [7:0] t0;
    logic [7:0] t1;
  } aexp_t;

  aexp_t      aq[$];
  logic [7:0] wq[$];
  logic [7:0] pend[$];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // mode: 0 init, 1 settle, 2 run, 3 flush
  int          mode   = 0;
  logic        err_m  = 1'b0;
  int          stall_m = 0;

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h cyc=%0d", name, got, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc++;

  // Reference model: evaluated at negedge while inputs are stable.
  always @(negedge clk) begin
    bit   active, run, e_fr, e_ar, e_wr, legal, was_empty;
    aexp_t e;
    if (!reset_n) begin
      mode = 0;
      pend.delete();
      wq.delete();
      aq.delete();
      err_m = 1'b0;
      stall_m = 0;
    end
    active = (mode >= 2);
    run    = (mode == 2);
    legal  = (alloc_cnt == 2'd1) || (alloc_cnt == 2'd2);
    e_fr   = active && (pend.size() <= D - 2);
    e_ar   = run && !flush && legal &&
             (int'(fl_freespace) >= int'(alloc_cnt) + RES);
    e_wr   = active && (pend.size() > 0);
    chk("fl_reset", fl_reset, (mode == 0));
    chk("alloc_ready", alloc_ready, e_ar);
    chk("free_ready", free_ready, e_fr);
    chk("fl_read_1", fl_read_1, e_ar && alloc_valid && alloc_cnt == 2'd1);
    chk("fl_read_2", fl_read_2, e_ar && alloc_valid && alloc_cnt == 2'd2);
    chk("fl_write", fl_write, e_wr);
    chk("err", err, err_m);
    chk("stall_cycles", stall_cycles, stall_m);
    if (reset_n) begin
      if (alloc_valid && e_ar) begin
        e.due = cyc + 1;
        e.vld = (alloc_cnt == 2'd2) ? 2'b11 : 2'b01;
        e.t0  = fl_tag0;
        e.t1  = fl_tag1;
        aq.push_back(e);
      end
      was_empty = (pend.size() == 0);
      if (e_wr) void'(pend.pop_front());
      if (e_fr) begin
        if (free0_valid) begin
          pend.push_back(free0_tag);
          wq.push_back(free0_tag);
        end
        if (free1_valid) begin
          pend.push_back(free1_tag);
          wq.push_back(free1_tag);
        end
      end else if (free0_valid || free1_valid) begin
        err_m = 1'b1;
      end
      if (alloc_valid && !legal) err_m = 1'b1;
      if (run && alloc_valid && !e_ar && stall_m != 65535) stall_m++;
      case (mode)
        0: mode = 1;
        1: mode = 2;
        2: if (flush) mode = 3;
        3: if (!flush && was_empty) mode = 2;
        default: mode = 0;
      endcase
    end
  end

  // Monitor: pops the scoreboard queues when the DUT presents output.
  always @(negedge clk) begin
    aexp_t e;
    #1;
    if (aq.size() > 0 && aq[0].due == cyc) begin
      e = aq.pop_front();
      chk("alloc_tag_vld", alloc_tag_vld, e.vld);
      chk("alloc_tag0", alloc_tag0, e.t0);
      if (e.vld[1]) chk("alloc_tag1", alloc_tag1, e.t1);
    end else begin
      chk("alloc_tag_vld_idle", alloc_tag_vld, 2'b00);
    end
    if (fl_write) begin
      if (wq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL fl_write_unexpected got=%0h exp=none", fl_write_tag);
      end else begin
        chk("fl_write_tag", fl_write_tag, wq.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    alloc_valid = 1'b0;
    alloc_cnt   = 2'd1;
    free0_valid = 1'b0;
    free1_valid = 1'b0;
    free0_tag   = '0;
    free1_tag   = '0;
    flush       = 1'b0;
  endtask

  initial begin
    reset_n      = 1'b0;
    fl_tag0      = '0;
    fl_tag1      = '0;
    fl_freespace = 8'd0;
    clr();
    repeat (3) tick();
    reset_n = 1'b1;
    repeat (3) tick();

    fl_freespace = 8'd5;
    alloc_valid  = 1'b1;
    alloc_cnt    = 2'd2;
    fl_tag0      = 8'h10;
    fl_tag1      = 8'h11;
    tick();
    alloc_valid = 1'b0;
    tick();

    fl_freespace = 8'd1;
    alloc_valid  = 1'b1;
    alloc_cnt    = 2'd2;
    fl_tag0      = 8'h12;
    repeat (3) tick();
    alloc_cnt = 2'd1;
    tick();
    clr();
    tick();

    free0_valid = 1'b1;
    free1_valid = 1'b1;
    free0_tag   = 8'h20;
    free1_tag   = 8'h21;
    tick();
    free0_tag = 8'h22;
    free1_tag = 8'h23;
    tick();
    clr();
    repeat (5) tick();

    free0_valid = 1'b1;
    free1_valid = 1'b1;
    free0_tag   = 8'h30;
    free1_tag   = 8'h31;
    tick();
    clr();
    flush        = 1'b1;
    alloc_valid  = 1'b1;
    alloc_cnt    = 2'd1;
    fl_freespace = 8'd8;
    repeat (3) tick();
    clr();
    repeat (3) tick();

    alloc_valid = 1'b1;
    alloc_cnt   = 2'd3;
    tick();
    clr();
    repeat (3) tick();

    free0_valid = 1'b1;
    free1_valid = 1'b1;
    free0_tag   = 8'h40;
    free1_tag   = 8'h41;
    tick();
    clr();
    reset_n = 1'b0;
    repeat (2) tick();
    reset_n = 1'b1;
    repeat (3) tick();

    for (int i = 0; i < 300; i++) begin
      alloc_valid  = 1'($urandom_range(0, 1));
      alloc_cnt    = 2'($urandom_range(1, 2));
      fl_freespace = 8'($urandom_range(0, 6));
      fl_tag0      = 8'($urandom);
      fl_tag1      = 8'($urandom);
      flush        = ($urandom_range(0, 15) == 0);
      free0_valid  = free_ready && ($urandom_range(0, 2) == 0);
      free1_valid  = free_ready && ($urandom_range(0, 2) == 0);
      free0_tag    = 8'($urandom);
      free1_tag    = 8'($urandom);
      tick();
    end

    clr();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < 200; i++) begin
      alloc_valid  = 1'($urandom_range(0, 1));
      alloc_cnt    = 2'($urandom_range(0, 3));
      fl_freespace = 8'($urandom_range(0, 4));
      fl_tag0      = 8'($urandom);
      fl_tag1      = 8'($urandom);
      flush        = ($urandom_range(0, 9) == 0);
      free0_valid  = ($urandom_range(0, 2) == 0);
      free1_valid  = ($urandom_range(0, 2) == 0);
      free0_tag    = 8'($urandom);
      free1_tag    = 8'($urandom);
      tick();
    end

    clr();
    repeat (10) tick();
    chk("write_queue_drained", wq.size(), 0);
    chk("alloc_queue_drained", aq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
